// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master side drives requests; the slave side owns data and flags.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr;
    logic [DATA_W-1:0] w_data;
    logic              rd;
    logic [DATA_W-1:0] r_data;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, w_data, rd,
        input  r_data, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO, 2^ADDR_W x DATA_W, registered read data, threshold flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to get sticky overflow/underflow registers.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_THR  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR  = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   w_ptr;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] r_data_q;
    logic              full_w;
    logic              empty_w;
    logic              wr_ok;
    logic              rd_ok;

    // Extra wrap bit distinguishes full from empty when addresses match
    assign empty_w = (w_ptr == r_ptr);
    assign full_w  = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
                     (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
    assign cnt     = w_ptr - r_ptr;
    assign wr_ok   = bus.wr && !full_w;
    assign rd_ok   = bus.rd && !empty_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            r_data_q <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                r_data_q <= mem[r_ptr[ADDR_W-1:0]];
                r_ptr    <= r_ptr + PTR_ONE;
            end
        end
    end

    // Array is never cleared; resetting the pointers discards its contents
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[w_ptr[ADDR_W-1:0]] <= bus.w_data;
        end
    end

    assign bus.r_data       = r_data_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = cnt;
    assign bus.almost_full  = (cnt >= AF_THR);
    assign bus.almost_empty = (cnt <= AE_THR);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr && full_w) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd && empty_w) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomized plus directed bench for sync_fifo_param against a queue model.
// Expected error flags follow SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sync_fifo_param #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] q [$];
    logic [DW-1:0] m_rdata;
    logic          m_ovf;
    logic          m_udf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all();
        int n;
        n = q.size();
        chk("count", 32'(bus.count), 32'(n));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("full", 32'(bus.full), 32'(n == DEPTH));
        chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        chk("r_data", 32'(bus.r_data), 32'(m_rdata));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_udf));
`else
        chk("overflow", 32'(bus.overflow), 32'd0);
        chk("underflow", 32'(bus.underflow), 32'd0);
`endif
    endtask

    task automatic cyc(input logic r_s, input logic w, input logic r,
                       input logic [DW-1:0] d);
        bit was_full;
        bit was_empty;
        rst        = r_s;
        bus.wr     = w;
        bus.rd     = r;
        bus.w_data = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r_s) begin
            q.delete();
            m_rdata = '0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            if (w && was_full) m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_rdata = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
        #1;
        chk_all();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        m_rdata    = '0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        rst        = 1'b1;
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.w_data = '0;

        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("rst_empty", 32'(bus.empty), 32'd1);

        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, DW'(i * 8'h11));
        end
        chk("fill_full", 32'(bus.full), 32'd1);

        cyc(1'b0, 1'b1, 1'b0, 8'h99);
        chk("ovf_count", 32'(bus.count), 32'd8);

        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, '0);
            chk("drain_data", 32'(bus.r_data), 32'(i * 8'h11));
        end

        cyc(1'b0, 1'b0, 1'b1, '0);
        chk("udf_rdata", 32'(bus.r_data), 32'h88);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, DW'(8'h20 + i));
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b1, DW'(8'h23 + i));
        end
        chk("stream_count", 32'(bus.count), 32'd3);

        cyc(1'b0, 1'b1, 1'b0, 8'h50);
        cyc(1'b0, 1'b1, 1'b0, 8'h51);
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        cyc(1'b1, 1'b1, 1'b1, 8'h52);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'hA5);
        cyc(1'b0, 1'b0, 1'b1, '0);
        chk("a5_read", 32'(bus.r_data), 32'hA5);

        for (int i = 0; i < 600; i++) begin
            logic rs;
            logic w;
            logic r;
            int   bias;
            bias = (i / 100) % 3;
            rs = ($urandom_range(0, 79) == 0);
            w  = ($urandom_range(0, 3) < (bias == 0 ? 3 : 1));
            r  = ($urandom_range(0, 3) < (bias == 1 ? 3 : 2));
            cyc(rs, w, r, DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
